// File: rtl/knap_pkg.sv
// Shared types and default sizing for the exhaustive knapsack subset search.
package knap_pkg;

  localparam int KNAP_N_ITEMS = 6;
  localparam int KNAP_VAL_W   = 6;
  // Item table storage width; instances may use any VAL_W up to this.
  localparam int KNAP_ITEM_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  typedef struct packed {
    logic [KNAP_ITEM_W-1:0] value;
    logic [KNAP_ITEM_W-1:0] weight;
    logic [KNAP_ITEM_W-1:0] volume;
  } item_t;

endpackage

// File: rtl/knap_eval.sv
// Combinational subset totals: sums value/weight/volume of every item selected by mask.
module knap_eval
  import knap_pkg::*;
#(
  parameter int N_ITEMS = KNAP_N_ITEMS,
  parameter int ACC_W   = KNAP_VAL_W + $clog2(KNAP_N_ITEMS) + 1
) (
  input  logic                  [N_ITEMS-1:0] mask,
  input  item_t [N_ITEMS-1:0]                 items,
  output logic                  [ACC_W-1:0]   sum_value,
  output logic                  [ACC_W-1:0]   sum_weight,
  output logic                  [ACC_W-1:0]   sum_volume
);

  always_comb begin
    sum_value  = '0;
    sum_weight = '0;
    sum_volume = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (mask[i]) begin
        // Stored fields are zero-extended, so truncating to ACC_W loses nothing.
        sum_value  = sum_value  + ACC_W'(items[i].value);
        sum_weight = sum_weight + ACC_W'(items[i].weight);
        sum_volume = sum_volume + ACC_W'(items[i].volume);
      end
    end
  end

endmodule

// File: rtl/knap_search.sv
// Brute-force knapsack search: walks every subset mask, one per cycle, through a
// two-stage sum/evaluate pipeline and keeps the best feasible subset.
module knap_search
  import knap_pkg::*;
#(
  parameter int N_ITEMS = KNAP_N_ITEMS,
  parameter int VAL_W   = KNAP_VAL_W,
  parameter int ACC_W   = VAL_W + $clog2(N_ITEMS) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ld_en,
  input  logic [$clog2(N_ITEMS)-1:0] ld_idx,
  input  logic [VAL_W-1:0]           ld_value,
  input  logic [VAL_W-1:0]           ld_weight,
  input  logic [VAL_W-1:0]           ld_volume,
  input  logic [VAL_W-1:0]           min_value,
  input  logic [VAL_W-1:0]           max_weight,
  input  logic [VAL_W-1:0]           max_volume,
  input  logic                       start,
  input  logic                       abort,
  output logic                       busy,
  output logic                       done,
  output logic                       found,
  output logic [N_ITEMS-1:0]         best_mask,
  output logic [ACC_W-1:0]           best_value,
  output logic [N_ITEMS:0]           feasible_count
);

  state_t                state_q, state_d;
  // Extra top bit marks "all masks issued" so the counter never wraps.
  logic [N_ITEMS:0]      cnt_q, cnt_d;
  item_t [N_ITEMS-1:0]   items_q, items_d;
  logic [VAL_W-1:0]      lim_min_q, lim_min_d, lim_w_q, lim_w_d, lim_v_q, lim_v_d;
  logic                  s1_vld_q, s1_vld_d;
  logic [N_ITEMS-1:0]    s1_mask_q, s1_mask_d;
  logic [ACC_W-1:0]      s1_val_q, s1_val_d, s1_wt_q, s1_wt_d, s1_vol_q, s1_vol_d;
  logic                  found_q, found_d;
  logic [N_ITEMS-1:0]    best_mask_q, best_mask_d;
  logic [ACC_W-1:0]      best_value_q, best_value_d;
  logic [N_ITEMS:0]      fcount_q, fcount_d;

  logic [ACC_W-1:0]      sum_value, sum_weight, sum_volume;
  logic                  issue, kill, feas;

  knap_eval #(.N_ITEMS(N_ITEMS), .ACC_W(ACC_W)) u_eval (
    .mask       (cnt_q[N_ITEMS-1:0]),
    .items      (items_q),
    .sum_value  (sum_value),
    .sum_weight (sum_weight),
    .sum_volume (sum_volume)
  );

  assign busy           = (state_q == ST_SEARCH) || (state_q == ST_DRAIN);
  assign done           = (state_q == ST_DONE);
  assign found          = found_q;
  assign best_mask      = best_mask_q;
  assign best_value     = best_value_q;
  assign feasible_count = fcount_q;

  assign issue = (state_q == ST_SEARCH) && !cnt_q[N_ITEMS];
  assign kill  = busy && abort;
  assign feas  = s1_vld_q && !kill
              && (s1_val_q >= ACC_W'(lim_min_q))
              && (s1_wt_q  <= ACC_W'(lim_w_q))
              && (s1_vol_q <= ACC_W'(lim_v_q));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    items_d      = items_q;
    lim_min_d    = lim_min_q;
    lim_w_d      = lim_w_q;
    lim_v_d      = lim_v_q;
    s1_vld_d     = issue && !kill;
    s1_mask_d    = s1_mask_q;
    s1_val_d     = s1_val_q;
    s1_wt_d      = s1_wt_q;
    s1_vol_d     = s1_vol_q;
    found_d      = found_q;
    best_mask_d  = best_mask_q;
    best_value_d = best_value_q;
    fcount_d     = fcount_q;

    if (issue) begin
      s1_mask_d = cnt_q[N_ITEMS-1:0];
      s1_val_d  = sum_value;
      s1_wt_d   = sum_weight;
      s1_vol_d  = sum_volume;
    end

    // Strict '>' keeps the lowest mask among equal-valued subsets.
    if (feas) begin
      fcount_d = fcount_q + 1'b1;
      if (!found_q || (s1_val_q > best_value_q)) begin
        found_d      = 1'b1;
        best_mask_d  = s1_mask_q;
        best_value_d = s1_val_q;
      end
    end

    if (!busy && ld_en && (int'(ld_idx) < N_ITEMS)) begin
      items_d[ld_idx] = '{value:  KNAP_ITEM_W'(ld_value),
                          weight: KNAP_ITEM_W'(ld_weight),
                          volume: KNAP_ITEM_W'(ld_volume)};
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_SEARCH;
          cnt_d        = '0;
          lim_min_d    = min_value;
          lim_w_d      = max_weight;
          lim_v_d      = max_volume;
          found_d      = 1'b0;
          best_mask_d  = '0;
          best_value_d = '0;
          fcount_d     = '0;
        end
      end
      ST_SEARCH: begin
        if (abort)      state_d = ST_IDLE;
        else if (issue) cnt_d   = cnt_q + 1'b1;
        else            state_d = ST_DRAIN;
      end
      ST_DRAIN: state_d = abort ? ST_IDLE : ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      items_q      <= '0;
      lim_min_q    <= '0;
      lim_w_q      <= '0;
      lim_v_q      <= '0;
      s1_vld_q     <= 1'b0;
      s1_mask_q    <= '0;
      s1_val_q     <= '0;
      s1_wt_q      <= '0;
      s1_vol_q     <= '0;
      found_q      <= 1'b0;
      best_mask_q  <= '0;
      best_value_q <= '0;
      fcount_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      items_q      <= items_d;
      lim_min_q    <= lim_min_d;
      lim_w_q      <= lim_w_d;
      lim_v_q      <= lim_v_d;
      s1_vld_q     <= s1_vld_d;
      s1_mask_q    <= s1_mask_d;
      s1_val_q     <= s1_val_d;
      s1_wt_q      <= s1_wt_d;
      s1_vol_q     <= s1_vol_d;
      found_q      <= found_d;
      best_mask_q  <= best_mask_d;
      best_value_q <= best_value_d;
      fcount_q     <= fcount_d;
    end
  end

endmodule

// File: tb/tb_knap_search.sv
// Directed bench for knap_search: 6-item default instance plus a 4-item instance.
module tb_knap_search;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  always #5 clk = ~clk;

  logic       ld_en = 0, start = 0, abort = 0;
  logic [2:0] ld_idx = 0;
  logic [5:0] ld_value = 0, ld_weight = 0, ld_volume = 0;
  logic [5:0] min_value = 0, max_weight = 0, max_volume = 0;
  logic       busy, done, found;
  logic [5:0] best_mask;
  logic [9:0] best_value;
  logic [6:0] feasible_count;

  logic       ld_en4 = 0, start4 = 0;
  logic [1:0] ld_idx4 = 0;
  logic [5:0] ld_value4 = 0, ld_weight4 = 0, ld_volume4 = 0;
  logic       busy4, done4, found4;
  logic [3:0] best_mask4;
  logic [8:0] best_value4;
  logic [4:0] feasible_count4;

  knap_search u_dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_idx(ld_idx),
    .ld_value(ld_value), .ld_weight(ld_weight), .ld_volume(ld_volume),
    .min_value(min_value), .max_weight(max_weight), .max_volume(max_volume),
    .start(start), .abort(abort), .busy(busy), .done(done), .found(found),
    .best_mask(best_mask), .best_value(best_value), .feasible_count(feasible_count)
  );

  knap_search #(.N_ITEMS(4)) u_dut4 (
    .clk(clk), .rst(rst), .ld_en(ld_en4), .ld_idx(ld_idx4),
    .ld_value(ld_value4), .ld_weight(ld_weight4), .ld_volume(ld_volume4),
    .min_value(6'd0), .max_weight(6'd63), .max_volume(6'd63),
    .start(start4), .abort(1'b0), .busy(busy4), .done(done4), .found(found4),
    .best_mask(best_mask4), .best_value(best_value4), .feasible_count(feasible_count4)
  );

  int n_vec = 0;
  int n_err = 0;

  // Items A..F as (value, weight, volume).
  logic [5:0] tv [6] = '{6'd4, 6'd2, 6'd2, 6'd1, 6'd10, 6'd20};
  logic [5:0] tw [6] = '{6'd12, 6'd1, 6'd2, 6'd1, 6'd4, 6'd1};
  logic [5:0] tl [6] = '{6'd10, 6'd2, 6'd1, 6'd4, 6'd3, 6'd12};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load6(input logic [2:0] idx, input logic [5:0] v, w, l);
    ld_en = 1; ld_idx = idx; ld_value = v; ld_weight = w; ld_volume = l;
    tick();
    ld_en = 0;
  endtask

  task automatic run6(input logic [5:0] mn, mw, mv, output int lat);
    min_value = mn; max_weight = mw; max_volume = mv; start = 1;
    tick();
    start = 0;
    lat = 0;
    while (!done && lat < 200) begin tick(); lat++; end
  endtask

  task automatic check_res(input string tag, input int lat, input logic f,
                           input logic [5:0] m, input logic [9:0] v, input logic [6:0] c);
    chk({tag, "_lat"},   32'(lat), 32'd66);
    chk({tag, "_found"}, 32'(found), 32'(f));
    chk({tag, "_mask"},  32'(best_mask), 32'(m));
    chk({tag, "_value"}, 32'(best_value), 32'(v));
    chk({tag, "_count"}, 32'(feasible_count), 32'(c));
    chk({tag, "_busy"},  32'(busy), 32'd0);
    tick();
    chk({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int lat;
    logic saw;
    #1;
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_found", 32'(found), 32'd0);
    chk("rst_mask",  32'(best_mask), 32'd0);
    chk("rst_value", 32'(best_value), 32'd0);
    chk("rst_count", 32'(feasible_count), 32'd0);
    #10 rst = 0;
    tick();

    for (int i = 0; i < 6; i++) load6(3'(i), tv[i], tw[i], tl[i]);
    load6(3'd7, 6'd63, 6'd0, 6'd0);

    run6(6'd15, 6'd16, 6'd10, lat);
    check_res("base", lat, 1'b1, 6'h1E, 10'd15, 7'd1);

    run6(6'd0, 6'd63, 6'd63, lat);
    check_res("all", lat, 1'b1, 6'h3F, 10'd39, 7'd64);

    run6(6'd63, 6'd0, 6'd0, lat);
    check_res("none", lat, 1'b0, 6'h00, 10'd0, 7'd0);

    // Abort mid-search, with a table write attempted while busy.
    min_value = 6'd15; max_weight = 6'd16; max_volume = 6'd10; start = 1;
    tick();
    start = 0;
    chk("ab_busy_on", 32'(busy), 32'd1);
    repeat (9) tick();
    load6(3'd5, 6'd63, 6'd0, 6'd0);
    repeat (9) tick();
    abort = 1; start = 1;
    tick();
    abort = 0; start = 0;
    chk("ab_busy_off", 32'(busy), 32'd0);
    saw = 0;
    for (int i = 0; i < 80; i++) begin
      if (done) saw = 1;
      tick();
    end
    chk("ab_nodone", 32'(saw), 32'd0);
    run6(6'd15, 6'd16, 6'd10, lat);
    check_res("after_ab", lat, 1'b1, 6'h1E, 10'd15, 7'd1);

    for (int i = 0; i < 6; i++) load6(3'(i), 6'd63, 6'd63, 6'd63);
    run6(6'd0, 6'd63, 6'd63, lat);
    check_res("tie", lat, 1'b1, 6'h01, 10'd63, 7'd7);

    // Asynchronous reset mid-search, between clock edges.
    min_value = 6'd0; max_weight = 6'd63; max_volume = 6'd63; start = 1;
    tick();
    start = 0;
    repeat (10) tick();
    chk("pre_rst_count", 32'(feasible_count != 0), 32'd1);
    #3 rst = 1;
    #1;
    chk("arst_busy",  32'(busy), 32'd0);
    chk("arst_found", 32'(found), 32'd0);
    chk("arst_count", 32'(feasible_count), 32'd0);
    chk("arst_value", 32'(best_value), 32'd0);
    #1 rst = 0;
    tick();
    chk("post_rst_idle", 32'(busy), 32'd0);
    // Table was cleared: every subset sums to zero.
    run6(6'd0, 6'd63, 6'd63, lat);
    check_res("zero_tbl", lat, 1'b1, 6'h00, 10'd0, 7'd64);

    for (int i = 0; i < 4; i++) begin
      ld_en4 = 1; ld_idx4 = 2'(i); ld_value4 = tv[i]; ld_weight4 = tw[i]; ld_volume4 = tl[i];
      tick();
    end
    ld_en4 = 0; start4 = 1;
    tick();
    start4 = 0;
    lat = 0;
    while (!done4 && lat < 100) begin tick(); lat++; end
    chk("n4_lat",   32'(lat), 32'd18);
    chk("n4_mask",  32'(best_mask4), 32'hF);
    chk("n4_value", 32'(best_value4), 32'd9);
    chk("n4_count", 32'(feasible_count4), 32'd16);
    chk("n4_found", 32'(found4), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
